data_mem_stage: RTL

DATA_MEM_STAGE -- requirements
Module: data_mem_stage

---
 rtl/data_mem_stage.sv | 104 ++++++++++
 1 files changed

// File: rtl/data_mem_stage.sv
// MEM pipeline stage: word-organised data RAM, access-fault detection,
// branch decision, and the MEM/WB pipeline register with stall support.
module data_mem_stage #(
  parameter int MEM_WORDS_LOG2 = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        write,
  input  logic        mem_read_MEM,
  input  logic        mem_write_MEM,
  input  logic        RegWrite_MEM,
  input  logic        MemtoReg_MEM,
  input  logic [31:0] address_MEM,
  input  logic [31:0] write_data_MEM,
  input  logic [31:0] PC_Branch_MEM,
  input  logic        ZERO_MEM,
  input  logic        Branch_MEM,
  input  logic [4:0]  RD_MEM,
  output logic        PCSrc_MEM,
  output logic [31:0] PC_Branch_out,
  output logic [31:0] read_data_WB,
  output logic [31:0] alu_result_WB,
  output logic [31:0] wb_data_WB,
  output logic [4:0]  RD_WB,
  output logic        RegWrite_WB,
  output logic        MemtoReg_WB,
  output logic        mem_fault_WB
);

  localparam int DEPTH = 1 << MEM_WORDS_LOG2;

  logic [31:0] r_mem [DEPTH];

  logic [MEM_WORDS_LOG2-1:0] w_idx;
  logic                      w_access;
  logic                      w_out_of_range;
  logic                      w_fault;
  logic                      w_mem_we;
  logic [31:0]               w_ram_q;
  logic [31:0]               w_load_data;
  logic [31:0]               w_wb_data;
  logic                      w_regwrite;

  logic [31:0] r_read_data;
  logic [31:0] r_alu_result;
  logic [31:0] r_wb_data;
  logic [4:0]  r_rd;
  logic        r_regwrite;
  logic        r_memtoreg;
  logic        r_fault;

  assign w_idx          = address_MEM[MEM_WORDS_LOG2+1:2];
  assign w_access       = mem_read_MEM | mem_write_MEM;
  assign w_out_of_range = (address_MEM >> (MEM_WORDS_LOG2 + 2)) != 32'd0;
  assign w_fault        = w_access & ((address_MEM[1:0] != 2'b00) | w_out_of_range);

  // A slot carrying both strobes is treated as a load only, so RAM is never
  // corrupted by a malformed instruction.
  assign w_mem_we = mem_write_MEM & ~mem_read_MEM & write & ~reset & ~w_fault;

  assign w_ram_q     = r_mem[w_idx];
  assign w_load_data = (mem_read_MEM & ~w_fault) ? w_ram_q : 32'd0;
  assign w_wb_data   = MemtoReg_MEM ? (w_fault ? 32'd0 : w_ram_q) : address_MEM;
  assign w_regwrite  = RegWrite_MEM & ~w_fault & (RD_MEM != 5'd0);

  assign PCSrc_MEM     = Branch_MEM & ZERO_MEM;
  assign PC_Branch_out = PC_Branch_MEM;

  // RAM contents survive reset; reset only gates the write enable.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_idx] <= write_data_MEM;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_read_data  <= 32'd0;
      r_alu_result <= 32'd0;
      r_wb_data    <= 32'd0;
      r_rd         <= 5'd0;
      r_regwrite   <= 1'b0;
      r_memtoreg   <= 1'b0;
      r_fault      <= 1'b0;
    end else if (write) begin
      r_read_data  <= w_load_data;
      r_alu_result <= address_MEM;
      r_wb_data    <= w_wb_data;
      r_rd         <= RD_MEM;
      r_regwrite   <= w_regwrite;
      r_memtoreg   <= MemtoReg_MEM;
      r_fault      <= w_fault;
    end
  end

  assign read_data_WB  = r_read_data;
  assign alu_result_WB = r_alu_result;
  assign wb_data_WB    = r_wb_data;
  assign RD_WB         = r_rd;
  assign RegWrite_WB   = r_regwrite;
  assign MemtoReg_WB   = r_memtoreg;
  assign mem_fault_WB  = r_fault;

endmodule
